apb_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one APB master between NREQ independent requesters.
- Sits in front of the APB master and drives its external command inputs: TX, APB_SLV_PADDR, APB_PWDATA and APB_SWRITE.
- Observes the APB bus (PSEL1/PSEL2, PEN, PREADY, PSLVERR, PRDATA) to detect when each transfer completes.
- Returns a per-requester response, and aborts a stalled transfer with a timeout error.

---
 rtl/apb_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 36 +++
 rtl/apb_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the APB request arbiter
package apb_arb_pkg;

    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder starting at ptr
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // Walk from the farthest slot back toward ptr so the nearest requester wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin sequencer sharing one APB master among NREQ requesters
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NREQ-1:0]          REQ_VALID,
    input  logic [NREQ-1:0]          REQ_WRITE,
    input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]          REQ_READY,
    output logic [NREQ-1:0]          RSP_VALID,
    output logic [DATA_W-1:0]        RSP_RDATA,
    output logic                     RSP_ERR,
    output logic                     TX,
    output logic [ADDR_W-1:0]        APB_SLV_PADDR,
    output logic [DATA_W-1:0]        APB_PWDATA,
    output logic                     APB_SWRITE,
    input  logic                     PSEL_ANY,
    input  logic                     PEN,
    input  logic                     PREADY,
    input  logic                     PSLVERR,
    input  logic [DATA_W-1:0]        PRDATA
);

    localparam int IW = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d, idx_q, idx_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_sel;
    logic [DATA_W-1:0] wdata_q, wdata_d, wdata_sel;
    logic              write_q, write_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              done, stall, expire;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req (REQ_VALID),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                addr_sel  = REQ_ADDR[i*ADDR_W +: ADDR_W];
                wdata_sel = REQ_WDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign done   = PSEL_ANY & PEN & PREADY;
    assign stall  = PSEL_ANY & PEN & ~PREADY;
    // PREADY is checked first, so a response on the threshold cycle is a normal completion.
    assign expire = stall & (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        ready_d  = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    addr_d  = addr_sel;
                    wdata_d = wdata_sel;
                    write_d = REQ_WRITE[pick_idx];
                    idx_d   = pick_idx;
                    ready_d = pick_gnt;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (done) begin
                    rdata_d = write_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end else if (expire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (stall) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            RESP: begin
                rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            ready_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        RSP_VALID = '0;
        if (state_q == RESP) begin
            RSP_VALID[idx_q] = 1'b1;
        end
    end

    assign RSP_RDATA     = (state_q == RESP) ? rdata_q : '0;
    assign RSP_ERR       = (state_q == RESP) & err_q;
    assign TX            = (state_q == XFER);
    assign REQ_READY     = ready_q;
    assign APB_SLV_PADDR = addr_q;
    assign APB_PWDATA    = wdata_q;
    assign APB_SWRITE    = write_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter with a bus model and reference model
module tb_apb_req_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 8;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [NREQ-1:0]   REQ_VALID, REQ_WRITE, REQ_READY, RSP_VALID;
    logic [NREQ*9-1:0] REQ_ADDR;
    logic [NREQ*8-1:0] REQ_WDATA;
    logic [7:0]        RSP_RDATA, APB_PWDATA, PRDATA;
    logic              RSP_ERR, TX, APB_SWRITE;
    logic [8:0]        APB_SLV_PADDR;
    logic              PSEL_ANY, PEN, PREADY, PSLVERR;

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .TW(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .TX(TX), .APB_SLV_PADDR(APB_SLV_PADDR), .APB_PWDATA(APB_PWDATA), .APB_SWRITE(APB_SWRITE),
        .PSEL_ANY(PSEL_ANY), .PEN(PEN), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc++;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Bus environment: APB master reacting to TX plus a configurable slave.
    int         mst = 0;
    int         wl  = 0;
    int         cfg_waits = 0;
    logic       cfg_hang = 1'b0, cfg_err = 1'b0, auto_drop = 1'b1;
    logic [7:0] cfg_rdata = 8'h00;

    task automatic tick();
        logic tx_s;
        @(negedge CLK);
        tx_s = TX;
        @(posedge CLK);
        #1;
        if (!RST_N) begin
            mst = 0;
        end else begin
            case (mst)
                0: if (tx_s) mst = 1;
                1: begin mst = 2; wl = cfg_waits; end
                default: if (!tx_s || PREADY) mst = 0; else if (wl > 0) wl--;
            endcase
        end
        PSEL_ANY = (mst != 0);
        PEN      = (mst == 2);
        PREADY   = (mst == 2) && (wl == 0) && !cfg_hang;
        PRDATA   = (mst == 2) ? cfg_rdata : 8'h00;
        PSLVERR  = PREADY && cfg_err;
        if (auto_drop) REQ_VALID = REQ_VALID & ~REQ_READY;
    endtask

    task automatic set_req(input int i, input logic [8:0] a, input logic [7:0] d, input logic w);
        REQ_ADDR[i*9 +: 9]  = a;
        REQ_WDATA[i*8 +: 8] = d;
        REQ_WRITE[i]        = w;
    endtask

    // Reference model: transaction timeline (decision cycle, completion cycle) and rotating pointer.
    int         t_dec = -1, t_end = -1, m_owner = 0, m_ptr = 0, m_stall = 0;
    logic [8:0] m_addr = '0;
    logic [7:0] m_wdata = '0, m_rdata = '0;
    logic       m_write = 1'b0, m_err = 1'b0;

    // Observation records used by the directed checks.
    int         rsp_cnt = 0, last_rsp_cyc = -100, last_ready_cyc = -100, acc_cnt = 0;
    logic [3:0] last_rsp_val = '0, last_ready_val = '0;
    logic [7:0] last_rsp_rdata = '0;
    logic       last_rsp_err = 1'b0;
    int         grant_q[$];
    int         gap_q[$];

    always @(negedge CLK) begin
        logic [NREQ-1:0] e_ready, e_rsp;
        logic            e_tx, free;
        int              w;
        if (!RST_N) begin
            t_dec = -1; t_end = -1; m_ptr = 0; m_stall = 0;
            m_addr = '0; m_wdata = '0; m_write = 1'b0; m_rdata = '0; m_err = 1'b0;
        end
        e_ready = '0;
        e_rsp   = '0;
        if (t_dec >= 0 && cyc == t_dec + 1) e_ready[m_owner] = 1'b1;
        if (t_end >= 0 && cyc == t_end + 1) e_rsp[m_owner] = 1'b1;
        e_tx = (t_dec >= 0) && (cyc > t_dec) && (t_end < 0 || cyc <= t_end);
        chk("req_ready", REQ_READY, e_ready);
        chk("rsp_valid", RSP_VALID, e_rsp);
        chk("tx", TX, e_tx);
        chk("rsp_rdata", RSP_RDATA, (e_rsp != 0) ? m_rdata : 8'h00);
        chk("rsp_err", RSP_ERR, (e_rsp != 0) ? m_err : 1'b0);
        chk("paddr", APB_SLV_PADDR, m_addr);
        chk("pwdata", APB_PWDATA, m_wdata);
        chk("swrite", APB_SWRITE, m_write);

        if (RST_N) begin
            free = (t_dec < 0) || (t_end >= 0 && cyc >= t_end + 2);
            if (free && REQ_VALID != 0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && REQ_VALID[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_owner = w; t_dec = cyc; t_end = -1; m_stall = 0;
                m_addr  = REQ_ADDR[w*9 +: 9];
                m_wdata = REQ_WDATA[w*8 +: 8];
                m_write = REQ_WRITE[w];
            end else if (t_dec >= 0 && t_end < 0 && cyc > t_dec && PSEL_ANY && PEN) begin
                if (PREADY) begin
                    t_end = cyc; m_err = PSLVERR; m_rdata = m_write ? 8'h00 : PRDATA;
                    m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    m_stall++;
                    if (m_stall == TO) begin
                        t_end = cyc; m_err = 1'b1; m_rdata = 8'h00;
                        m_ptr = (m_owner + 1) % NREQ;
                    end
                end
            end
        end

        if (REQ_READY != 0) begin
            for (int k = 0; k < NREQ; k++) if (REQ_READY[k]) grant_q.push_back(k);
            gap_q.push_back(cyc - last_rsp_cyc);
            last_ready_cyc = cyc; last_ready_val = REQ_READY; acc_cnt = 0;
        end
        if (TX && PSEL_ANY && PEN) acc_cnt++;
        if (RSP_VALID != 0) begin
            rsp_cnt++; last_rsp_cyc = cyc; last_rsp_val = RSP_VALID;
            last_rsp_rdata = RSP_RDATA; last_rsp_err = RSP_ERR;
        end
    end

    task automatic wait_rsp(input string nm, input int bound);
        int n0;
        int k;
        n0 = rsp_cnt;
        k  = 0;
        while (rsp_cnt == n0 && k < bound) begin
            tick();
            k++;
        end
        chk({nm, "_rsp_seen"}, (rsp_cnt != n0), 1'b1);
    endtask

    initial begin
        int t0, g0, n0, k;
        RST_N = 1'b0; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        PSEL_ANY = 1'b0; PEN = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        repeat (3) tick();
        chk("rst_tx", TX, 1'b0);
        chk("rst_ready", REQ_READY, 4'h0);
        chk("rst_rsp", RSP_VALID, 4'h0);
        chk("rst_paddr", APB_SLV_PADDR, 9'h000);
        RST_N = 1'b1;
        tick();

        // Single write, zero-wait slave.
        set_req(0, 9'h005, 8'hA5, 1'b1);
        cfg_waits = 0; REQ_VALID = 4'b0001; t0 = cyc;
        wait_rsp("t1", 20);
        chk("t1_ready_lat", last_ready_cyc - t0, 1);
        chk("t1_ready_val", last_ready_val, 4'b0001);
        chk("t1_pwdata", APB_PWDATA, 8'hA5);
        chk("t1_paddr", APB_SLV_PADDR, 9'h005);
        chk("t1_rsp_lat", last_rsp_cyc - t0, 4);
        chk("t1_rsp_val", last_rsp_val, 4'b0001);
        chk("t1_rsp_err", last_rsp_err, 1'b0);

        // Read with three wait states.
        set_req(2, 9'h105, 8'h00, 1'b0);
        cfg_waits = 3; cfg_rdata = 8'h3C; REQ_VALID = 4'b0100; t0 = cyc;
        wait_rsp("t2", 30);
        chk("t2_rsp_lat", last_rsp_cyc - t0, 7);
        chk("t2_rsp_val", last_rsp_val, 4'b0100);
        chk("t2_rdata", last_rsp_rdata, 8'h3C);
        chk("t2_err", last_rsp_err, 1'b0);

        // Slave error on a write; read data must not leak through.
        set_req(1, 9'h0AA, 8'h5A, 1'b1);
        cfg_waits = 0; cfg_err = 1'b1; cfg_rdata = 8'h77; REQ_VALID = 4'b0010;
        wait_rsp("t3", 20);
        chk("t3_rsp_val", last_rsp_val, 4'b0010);
        chk("t3_err", last_rsp_err, 1'b1);
        chk("t3_rdata", last_rsp_rdata, 8'h00);
        cfg_err = 1'b0;

        // Reset during the ACCESS phase of a stalled read.
        set_req(3, 9'h133, 8'h00, 1'b0);
        cfg_waits = 6; REQ_VALID = 4'b1000; n0 = rsp_cnt; k = 0;
        while (mst != 2 && k < 20) begin tick(); k++; end
        chk("t4_reached_access", (mst == 2), 1'b1);
        tick();
        RST_N = 1'b0;
        #1;
        chk("t4_tx", TX, 1'b0);
        chk("t4_ready", REQ_READY, 4'h0);
        chk("t4_rsp", RSP_VALID, 4'h0);
        REQ_VALID = '0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (3) tick();
        chk("t4_no_rsp", rsp_cnt - n0, 0);

        // Contention with all requesters held high.
        for (int i = 0; i < NREQ; i++) set_req(i, 9'(i * 64 + 3), 8'(8'h10 + i), i[0]);
        cfg_waits = 0; cfg_rdata = 8'h42; auto_drop = 1'b0;
        g0 = grant_q.size(); REQ_VALID = 4'b1111; k = 0;
        while (grant_q.size() < g0 + 5 && k < 60) begin tick(); k++; end
        chk("t5_five_grants", (grant_q.size() >= g0 + 5), 1'b1);
        REQ_VALID = '0; auto_drop = 1'b1;
        wait_rsp("t5", 20);
        if (grant_q.size() >= g0 + 5) begin
            chk("t5_g0", grant_q[g0], 0);
            chk("t5_g1", grant_q[g0+1], 1);
            chk("t5_g2", grant_q[g0+2], 2);
            chk("t5_g3", grant_q[g0+3], 3);
            chk("t5_g4", grant_q[g0+4], 0);
            for (int j = 1; j < 5; j++) chk("t5_gap", gap_q[g0+j], 2);
        end

        // Timeout on requester 1, then requester 3 queued behind it.
        set_req(1, 9'h011, 8'hC3, 1'b1);
        set_req(3, 9'h133, 8'h00, 1'b0);
        cfg_hang = 1'b1; cfg_rdata = 8'h9E; REQ_VALID = 4'b1010; t0 = cyc;
        wait_rsp("t6", 40);
        chk("t6_rsp_val", last_rsp_val, 4'b0010);
        chk("t6_err", last_rsp_err, 1'b1);
        chk("t6_rdata", last_rsp_rdata, 8'h00);
        chk("t6_access_cycles", acc_cnt, TO);
        chk("t6_rsp_lat", last_rsp_cyc - t0, 11);
        cfg_hang = 1'b0;
        g0 = grant_q.size();
        wait_rsp("t6b", 20);
        chk("t6b_granted", (grant_q.size() > g0), 1'b1);
        if (grant_q.size() > g0) begin
            chk("t6b_winner", grant_q[g0], 3);
            chk("t6b_gap", gap_q[g0], 2);
        end
        chk("t6b_rsp_val", last_rsp_val, 4'b1000);
        chk("t6b_rdata", last_rsp_rdata, 8'h9E);
        chk("t6b_err", last_rsp_err, 1'b0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
